// File: rtl/float_to_int16_sync.sv
// rtl/float_to_int16_sync.sv - binary32 to saturating int16 converter, valid-tagged pipeline
// Input capture register, decode stage, then shift/round/saturate stage.

module float_to_int16_sync #(
   parameter int ROUND_MODE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in,
   output logic        out_valid,
   output logic [15:0] out,
   output logic        overflow,
   output logic        invalid
);

   logic               v0_q, v1_q, out_valid_q;
   logic [31:0]        in_q;

   logic               s1_q, zero1_q, nan1_q, inf1_q;
   logic signed [8:0]  exp1_q;
   logic [23:0]        m1_q;

   logic               s_d, zero_d, nan_d, inf_d;
   logic signed [8:0]  exp_d;
   logic [23:0]        m_d;

   logic [15:0]        out_q, res_d;
   logic               ovf_q, inv_q, ovf_d, inv_d;

   logic signed [9:0]  sh_full;
   logic [5:0]         sh;
   logic [47:0]        ext;
   logic [23:0]        int_part;
   logic               guard, sticky, rnd, big;
   logic [24:0]        mag;

   always_comb begin
      s_d    = in_q[31];
      exp_d  = $signed({1'b0, in_q[30:23]}) - 9'sd127;
      m_d    = {(in_q[30:23] != 8'd0), in_q[22:0]};
      zero_d = (in_q[30:23] == 8'd0);
      nan_d  = (&in_q[30:23]) && (|in_q[22:0]);
      inf_d  = (&in_q[30:23]) && !(|in_q[22:0]);
   end

   // Shift of 24 (E == -1) leaves the hidden bit as guard, so 0.5 < x < 1 rounds like any other fraction.
   always_comb begin
      sh_full = 10'sd23 - $signed({exp1_q[8], exp1_q});
      if (sh_full > 10'sd47)
         sh = 6'd48;
      else if (sh_full < 10'sd0)
         sh = 6'd0;
      else
         sh = sh_full[5:0];
      ext      = {m1_q, 24'd0} >> sh;
      int_part = ext[47:24];
      guard    = ext[23];
      sticky   = |ext[22:0];
      rnd      = (ROUND_MODE == 1) && guard && (sticky || int_part[0]);
      mag      = {1'b0, int_part} + {24'd0, rnd};
      // Any exponent above 15 is at least 65536, so left shifts are never needed.
      big      = (exp1_q > 9'sd15);
   end

   always_comb begin
      res_d = 16'd0;
      ovf_d = 1'b0;
      inv_d = 1'b0;
      if (nan1_q) begin
         inv_d = 1'b1;
      end else if (zero1_q) begin
         res_d = 16'd0;
      end else if (inf1_q || big || (s1_q ? (mag > 25'd32768) : (mag > 25'd32767))) begin
         ovf_d = 1'b1;
         res_d = s1_q ? 16'h8000 : 16'h7FFF;
      end else if (s1_q) begin
         res_d = 16'(17'd0 - mag[16:0]);
      end else begin
         res_d = mag[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= 16'd0;
         ovf_q       <= 1'b0;
         inv_q       <= 1'b0;
      end else begin
         v0_q        <= in_valid;
         v1_q        <= v0_q;
         out_valid_q <= v1_q;
         if (v1_q) begin
            out_q <= res_d;
            ovf_q <= ovf_d;
            inv_q <= inv_d;
         end
      end
      if (in_valid)
         in_q <= in;
      if (v0_q) begin
         s1_q    <= s_d;
         exp1_q  <= exp_d;
         m1_q    <= m_d;
         zero1_q <= zero_d;
         nan1_q  <= nan_d;
         inf1_q  <= inf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign overflow  = ovf_q;
   assign invalid   = inv_q;

endmodule

// File: tb/tb_float_to_int16_sync.sv
// tb/tb_float_to_int16_sync.sv - directed bench for float_to_int16_sync, truncate and round instances

module tb_float_to_int16_sync;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_v;
   logic [31:0] in_d;
   logic        ov0, ov1, of0, of1, iv0, iv1;
   logic [15:0] o0, o1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   float_to_int16_sync #(.ROUND_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_v), .in(in_d),
      .out_valid(ov0), .out(o0), .overflow(of0), .invalid(iv0)
   );

   float_to_int16_sync #(.ROUND_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_v), .in(in_d),
      .out_valid(ov1), .out(o1), .overflow(of1), .invalid(iv1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic vec(input string tag, input logic [31:0] x,
                      input logic [15:0] r0, input logic f0, input logic n0,
                      input logic [15:0] r1, input logic f1, input logic n1);
      @(negedge clk);
      in_v = 1'b1;
      in_d = x;
      @(negedge clk);
      in_v = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_early_valid"}, {31'd0, ov0}, 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_valid0"}, {31'd0, ov0}, 32'd1);
      chk({tag, "_valid1"}, {31'd0, ov1}, 32'd1);
      chk({tag, "_out0"},   {16'd0, o0},  {16'd0, r0});
      chk({tag, "_ovf0"},   {31'd0, of0}, {31'd0, f0});
      chk({tag, "_inv0"},   {31'd0, iv0}, {31'd0, n0});
      chk({tag, "_out1"},   {16'd0, o1},  {16'd0, r1});
      chk({tag, "_ovf1"},   {31'd0, of1}, {31'd0, f1});
      chk({tag, "_inv1"},   {31'd0, iv1}, {31'd0, n1});
   endtask

   logic [31:0] stream [10];

   initial begin
      rst  = 1'b1;
      in_v = 1'b0;
      in_d = 32'd0;
      stream = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", {31'd0, ov0}, 32'd0);
      chk("reset_out",   {16'd0, o0},  32'd0);
      chk("reset_ovf",   {31'd0, of0}, 32'd0);
      chk("reset_inv",   {31'd0, iv1}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      vec("neg1024",  32'hC4800000, 16'hFC00, 0, 0, 16'hFC00, 0, 0);
      vec("zero",     32'h00000000, 16'h0000, 0, 0, 16'h0000, 0, 0);
      vec("one",      32'h3F800000, 16'h0001, 0, 0, 16'h0001, 0, 0);
      vec("p1024",    32'h44800000, 16'h0400, 0, 0, 16'h0400, 0, 0);
      vec("neg100",   32'hC2C80000, 16'hFF9C, 0, 0, 16'hFF9C, 0, 0);
      vec("p2_5",     32'h40200000, 16'h0002, 0, 0, 16'h0002, 0, 0);
      vec("p5_5",     32'h40B00000, 16'h0005, 0, 0, 16'h0006, 0, 0);
      vec("p20_2",    32'h41A1999A, 16'h0014, 0, 0, 16'h0014, 0, 0);
      vec("p500",     32'h43FA0000, 16'h01F4, 0, 0, 16'h01F4, 0, 0);
      vec("p10",      32'h41200000, 16'h000A, 0, 0, 16'h000A, 0, 0);
      vec("n1_5",     32'hBFC00000, 16'hFFFF, 0, 0, 16'hFFFE, 0, 0);
      vec("p32768",   32'h47000000, 16'h7FFF, 1, 0, 16'h7FFF, 1, 0);
      vec("n32768",   32'hC7000000, 16'h8000, 0, 0, 16'h8000, 0, 0);
      vec("n32769",   32'hC7000100, 16'h8000, 1, 0, 16'h8000, 1, 0);
      vec("pinf",     32'h7F800000, 16'h7FFF, 1, 0, 16'h7FFF, 1, 0);
      vec("ninf",     32'hFF800000, 16'h8000, 1, 0, 16'h8000, 1, 0);
      vec("nan",      32'h7FC00000, 16'h0000, 0, 1, 16'h0000, 0, 1);
      vec("nnan",     32'hFFC00001, 16'h0000, 0, 1, 16'h0000, 0, 1);
      vec("denorm",   32'h80000001, 16'h0000, 0, 0, 16'h0000, 0, 0);
      vec("negzero",  32'h80000000, 16'h0000, 0, 0, 16'h0000, 0, 0);
      vec("half",     32'h3F000000, 16'h0000, 0, 0, 16'h0000, 0, 0);
      vec("p0_75",    32'h3F400000, 16'h0000, 0, 0, 16'h0001, 0, 0);
      vec("p32767_5", 32'h46FFFF00, 16'h7FFF, 0, 0, 16'h7FFF, 1, 0);

      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         in_v = (c < 10);
         in_d = (c < 10) ? stream[c] : 32'd0;
         @(posedge clk);
         #1;
         chk($sformatf("stream_valid_%0d", c), {31'd0, ov0}, {31'd0, (c >= 2 && c < 12)});
         if (c >= 2 && c < 12)
            chk($sformatf("stream_out_%0d", c), {16'd0, o0}, 32'(c - 1));
      end

      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         rst  = (c == 4);
         in_v = (c <= 4);
         in_d = stream[c];
         @(posedge clk);
         #1;
         if (c == 4) begin
            chk("midrst_valid", {31'd0, ov0}, 32'd0);
            chk("midrst_out",   {16'd0, o0},  32'd0);
         end else if (c > 4) begin
            chk($sformatf("no_stale_%0d", c), {31'd0, ov0 | ov1}, 32'd0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
